// File: rtl/rv32i_memport_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// The arbiter uses the slave view; the requesters and the memory together use the master view.
interface rv32i_memport_arbiter_if;
   logic        if_req;
   logic [29:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [29:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rv32i_memport_arbiter.sv
// Shares one memory port between fetch and load/store; data wins, one-cycle read return.
// Define FETCH_STARVE_GUARD_EN to let a fetch denied STARVE_LIMIT cycles in a row win once.
module rv32i_memport_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   rv32i_memport_arbiter_if.slave bus
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_IF_RD,
      OWN_DM_RD
   } owner_t;

   owner_t owner_q, owner_d;
   logic   if_win, dm_win;
   logic   starve_trip;

`ifdef FETCH_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;

   assign starve_trip = bus.if_req && (starve_q == 4'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end

   // Counts consecutive denied fetch cycles; a trip grants fetch, which clears it.
   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req || if_win)
         starve_d = '0;
      else if (starve_q != 4'(STARVE_LIMIT))
         starve_d = starve_q + 4'd1;
   end
`else
   assign starve_trip = 1'b0;
`endif

   always_comb begin
      if_win = 1'b0;
      dm_win = 1'b0;
      if (!reset) begin
         if (bus.dm_req && !starve_trip) dm_win = 1'b1;
         else if (bus.if_req)            if_win = 1'b1;
      end
   end

   // NOTE: non-blocking assignment for every clocked register so all flops sample
   // the same pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) owner_q <= OWN_IDLE;
      else       owner_q <= owner_d;
   end

   // NOTE: every output of this block gets a default first so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      owner_d       = OWN_IDLE;
      bus.if_gnt    = 1'b0;
      bus.dm_gnt    = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'h0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (dm_win) begin
         bus.dm_gnt    = 1'b1;
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.dm_we;
         bus.mem_be    = bus.dm_be;
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
         owner_d       = bus.dm_we ? OWN_IDLE : OWN_DM_RD;
      end else if (if_win) begin
         bus.if_gnt    = 1'b1;
         bus.mem_en    = 1'b1;
         bus.mem_be    = 4'hF;
         bus.mem_addr  = bus.if_addr;
         owner_d       = OWN_IF_RD;
      end
   end

   // Reset gating also drops a read granted just before reset asserted.
   assign bus.if_rvalid = !reset && (owner_q == OWN_IF_RD);
   assign bus.dm_rvalid = !reset && (owner_q == OWN_DM_RD);
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.dm_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_rv32i_memport_arbiter.sv
// Scoreboard bench for rv32i_memport_arbiter: directed scenarios followed by random traffic.
// Build with or without FETCH_STARVE_GUARD_EN; the reference model follows the same define.
module tb_rv32i_memport_arbiter;
   localparam int LIMIT = 4;
`ifdef FETCH_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rv32i_memport_arbiter_if bus();

   rv32i_memport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          due;
      bit          to_dm;
      logic [31:0] data;
   } rd_t;

   rd_t         rdq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          starve   = 0;
   bit          exp_if_gnt = 1'b0;
   bit          exp_dm_gnt = 1'b0;
   logic        pend;
   logic [29:0] pend_addr;

   function automatic logic [31:0] mem_word(logic [29:0] a);
      return {a, 2'b10} ^ 32'h5A5A_1234;
   endfunction

   task automatic check(string name, logic [95:0] act, logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: registered read of whatever address was presented with mem_en and mem_we=0.
   initial begin
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         pend      = bus.mem_en && !bus.mem_we;
         pend_addr = bus.mem_addr;
         @(posedge clk);
         #1;
         bus.mem_rdata = pend ? mem_word(pend_addr) : $urandom;
      end
   end

   // Reference model: decide the winner from the rules, check the port, queue expected returns.
   always @(negedge clk) begin : predictor
      logic [69:0] exp_v;
      logic [69:0] act_v;
      bit          trip;
      exp_if_gnt = 1'b0;
      exp_dm_gnt = 1'b0;
      exp_v      = '0;
      if (reset) begin
         starve = 0;
      end else begin
         trip = GUARD && bus.if_req && (starve == LIMIT);
         if (bus.dm_req && !trip) exp_dm_gnt = 1'b1;
         else if (bus.if_req)     exp_if_gnt = 1'b1;
         if (exp_dm_gnt) begin
            exp_v = {2'b01, 1'b1, bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wdata};
            if (!bus.dm_we) rdq.push_back('{cyc + 1, 1'b1, mem_word(bus.dm_addr)});
         end else if (exp_if_gnt) begin
            exp_v = {2'b10, 1'b1, 1'b0, 4'hF, bus.if_addr, 32'h0};
            rdq.push_back('{cyc + 1, 1'b0, mem_word(bus.if_addr)});
         end
         if (!bus.if_req || exp_if_gnt) starve = 0;
         else if (starve < LIMIT)       starve = starve + 1;
      end
      act_v = {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_be,
               bus.mem_addr, bus.mem_wdata};
      check("port_outputs", act_v, exp_v);
   end

   // Monitor: rvalid must match the queued return due this cycle, data must match the model.
   always @(negedge clk) begin : monitor
      bit due_if;
      bit due_dm;
      due_if = 1'b0;
      due_dm = 1'b0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
         due_if = !rdq[0].to_dm;
         due_dm = rdq[0].to_dm;
         if (reset) begin
            due_if = 1'b0;
            due_dm = 1'b0;
            void'(rdq.pop_front());
         end
      end
      check("if_rvalid", bus.if_rvalid, due_if);
      check("dm_rvalid", bus.dm_rvalid, due_dm);
      if (due_if) begin
         check("if_rdata", bus.if_rdata, rdq[0].data);
         void'(rdq.pop_front());
      end else if (due_dm) begin
         check("dm_rdata", bus.dm_rdata, rdq[0].data);
         void'(rdq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_if(bit r, logic [29:0] a);
      bus.if_req  = r;
      bus.if_addr = a;
   endtask

   task automatic set_dm(bit r, bit we, logic [3:0] be, logic [29:0] a, logic [31:0] d);
      bus.dm_req   = r;
      bus.dm_we    = we;
      bus.dm_be    = be;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
   endtask

   initial begin
      reset = 1'b1;
      set_if(1'b0, '0);
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      repeat (3) step();
      reset = 1'b0;

      // Fetch only, three back-to-back grants.
      set_if(1'b1, 30'h10);
      repeat (3) step();
      set_if(1'b0, '0);
      step();

      // Contention: load wins, fetch keeps requesting and follows.
      set_if(1'b1, 30'h20);
      set_dm(1'b1, 1'b0, 4'hF, 30'h3A5, '0);
      step();
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      step();
      set_if(1'b0, '0);
      step();

      // Store with partial byte enables.
      set_dm(1'b1, 1'b1, 4'b0011, 30'h44, 32'hDEADBEEF);
      step();
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // Starvation: both held for ten cycles from a cleared counter.
      set_if(1'b1, 30'h55);
      set_dm(1'b1, 1'b0, 4'hF, 30'h66, '0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("starve_pattern", {bus.if_gnt, bus.dm_gnt},
               (GUARD && (k % (LIMIT + 1) == 0)) ? 2'b10 : 2'b01);
         step();
      end
      set_if(1'b0, '0);
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // Reset in the cycle after a granted load drops the return.
      set_dm(1'b1, 1'b0, 4'hF, 30'h77, '0);
      step();
      reset = 1'b1;
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      check("reset_drops_dm_rvalid", bus.dm_rvalid, 1'b0);
      step();
      reset = 1'b0;
      set_if(1'b1, 30'h88);
      @(negedge clk);
      check("post_reset_if_gnt", bus.if_gnt, 1'b1);
      step();
      set_if(1'b0, '0);
      step();

      // Random traffic; requesters hold until granted, occasionally abandon, rare resets.
      for (int i = 0; i < 3000; i++) begin
         if (!bus.if_req || exp_if_gnt) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = 30'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            bus.if_req = 1'b0;
         end
         if (!bus.dm_req || exp_dm_gnt) begin
            set_dm($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   4'($urandom), 30'($urandom), $urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            bus.dm_req = 1'b0;
         end
         reset = ($urandom_range(0, 149) == 0);
         step();
      end

      reset = 1'b0;
      set_if(1'b0, '0);
      set_dm(1'b0, 1'b0, 4'h0, '0, '0);
      repeat (3) step();
      check("queue_drained", rdq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
